// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MIPS memory-access stage: bundle layouts and FSM encoding.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
package mem_stage_pkg;

  // Both pipeline bundles are 71 bits wide
  localparam int BUNDLE_W = 71;

  // EX/MEM bundle fields
  localparam int EXM_MEM_READ  = 70;
  localparam int EXM_MEM_WRITE = 69;
  localparam int EXM_ALU_MSB   = 68;
  localparam int EXM_ALU_LSB   = 37;
  localparam int EXM_WD_MSB    = 36;
  localparam int EXM_WD_LSB    = 5;

  // MEM/WB bundle fields
  localparam int MWB_REG_WRITE  = 70;
  localparam int MWB_MEM_TO_REG = 69;
  localparam int MWB_RDATA_MSB  = 68;
  localparam int MWB_RDATA_LSB  = 37;
  localparam int MWB_ALU_MSB    = 36;
  localparam int MWB_ALU_LSB    = 5;

  // Destination register field sits at the bottom of both bundles
  localparam int RD_MSB = 4;
  localparam int RD_LSB = 0;

  // Access-latency counter width
  localparam int CNT_W = 4;

  // IDLE: no access in flight (cnt=0); WAIT: access counting (cnt>0)
  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  // Word accesses need the two low address bits clear
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/data_ram.sv
// Word-wide data RAM: DEPTH x 32, one shared address for read and write.
// Latency: combinational read, write lands on the rising edge when i_we is high.
// Backpressure: none; contents survive reset (no reset on the array).
module data_ram #(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [31:0]              i_wdata,
  output logic [31:0]              o_rdata
);

  logic [31:0] r_mem [DEPTH];

  // Synchronous write port
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: decodes EX/MEM, runs word loads/stores on the data RAM, registers MEM/WB.
// Latency: ALU ops and misaligned accesses 1 edge; aligned loads/stores MEM_LATENCY edges.
// Backpressure: mem_stall (combinational) holds upstream while an aligned access is counting.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int MEM_LATENCY = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BUNDLE_W-1:0] ex_mem_bundle,
  input  logic                ex_mem_valid,
  output logic                mem_stall,
  output logic [BUNDLE_W-1:0] mem_wb_bundle,
  output logic                mem_wb_valid,
  output logic                misalign_err
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LATENCY - 1);

  logic                w_mem_read;
  logic                w_mem_write;
  logic                w_load;
  logic                w_store;
  logic                w_misalign;
  logic                w_access;
  logic                w_last;
  logic                w_complete;
  logic                w_ram_we;
  logic                w_reg_write;
  logic [31:0]         w_alu;
  logic [31:0]         w_wdata;
  logic [31:0]         w_rdata;
  logic [31:0]         w_read_data;
  logic [4:0]          w_rd;
  logic [IW-1:0]       w_idx;
  logic [BUNDLE_W-1:0] w_wb_nxt;
  state_e              r_state;
  state_e              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;

  // Field extraction and decode; store wins when both read and write are set
  assign w_mem_read  = ex_mem_bundle[EXM_MEM_READ];
  assign w_mem_write = ex_mem_bundle[EXM_MEM_WRITE];
  assign w_alu       = ex_mem_bundle[EXM_ALU_MSB:EXM_ALU_LSB];
  assign w_wdata     = ex_mem_bundle[EXM_WD_MSB:EXM_WD_LSB];
  assign w_rd        = ex_mem_bundle[RD_MSB:RD_LSB];
  assign w_idx       = w_alu[IW+1:2];

  assign w_store    = w_mem_write;
  assign w_load     = w_mem_read & ~w_mem_write;
  assign w_misalign = (w_load | w_store) & is_misaligned(w_alu);
  assign w_access   = ex_mem_valid & (w_load | w_store) & ~w_misalign;

  // Final counting cycle of an access; with single-cycle latency every access is final
  assign w_last = (MEM_LATENCY == 1) || ((r_state == S_WAIT) && (r_cnt == LAST_CNT));

  // State register: counter and IDLE/WAIT state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: count while an aligned access is still short of its last cycle, else clear
  always_comb begin
    w_cnt_nxt = '0;
    if (w_access && !w_last) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
    w_state_nxt = (w_cnt_nxt != '0) ? S_WAIT : S_IDLE;
  end

  // Outputs of the FSM: stall, completion and RAM write strobe (all quiet in reset)
  always_comb begin
    mem_stall  = reset & w_access & ~w_last;
    w_complete = ex_mem_valid & ~(w_access & ~w_last);
    w_ram_we   = reset & w_access & w_last & w_store;
  end

  data_ram #(
    .DEPTH (DEPTH)
  ) u_data_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_idx),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  assign w_reg_write = (w_rd != 5'd0) & ~w_store & ~w_misalign;
  assign w_read_data = (w_load & ~w_misalign) ? w_rdata : 32'd0;
  assign w_wb_nxt    = {w_reg_write, w_load, w_read_data, w_alu, w_rd};

  // MEM/WB register: bundle only updates on completion, valid and error every edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_wb_bundle <= '0;
      mem_wb_valid  <= 1'b0;
      misalign_err  <= 1'b0;
    end else begin
      mem_wb_valid <= w_complete;
      misalign_err <= ex_mem_valid & w_misalign;
      if (w_complete) begin
        mem_wb_bundle <= w_wb_nxt;
      end
    end
  end

endmodule
